// File: rtl/mem_stream_reader.sv
`default_nettype none
// mem_stream_reader: walks a single-port memory and streams words out over valid/ready.
// Optional fill mode (writes a constant over an address range) is enabled by defining MEM_FILL_EN. Rev 1.0
module mem_stream_reader #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [AW-1:0]    cmd_start,
  input  logic [AW:0]      cmd_count,
`ifdef MEM_FILL_EN
  input  logic             cmd_fill,
  input  logic [WIDTH-1:0] cmd_fill_data,
`endif
  output logic [AW-1:0]    mem_address,
  output logic [WIDTH-1:0] mem_w_data,
  output logic             mem_w_write,
  input  logic [WIDTH-1:0] mem_r_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [AW:0]   REM_ONE   = (AW+1)'(1);

`ifdef MEM_FILL_EN
  typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, FILL = 2'd2} state_t;
`else
  typedef enum logic [0:0] {IDLE = 1'b0, READ = 1'b1} state_t;
`endif

  state_t          state, state_next;
  logic [AW-1:0]   addr, addr_next;
  logic [AW:0]     remaining;
  logic            start_cmd;
  logic            load;
  logic            step;
`ifdef MEM_FILL_EN
  logic [WIDTH-1:0] fill_data;
`endif

  assign addr_next   = (addr == LAST_ADDR) ? '0 : addr + 1'b1;
  assign mem_address = addr;
  assign busy        = (state != IDLE) || out_valid;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    cmd_ready   = 1'b0;
    start_cmd   = 1'b0;
    load        = 1'b0;
    step        = 1'b0;
    mem_w_write = 1'b0;
    mem_w_data  = '0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        // A zero-length command is accepted and silently dropped.
        if (cmd_valid && (cmd_count != '0)) begin
          start_cmd  = 1'b1;
`ifdef MEM_FILL_EN
          state_next = cmd_fill ? FILL : READ;
`else
          state_next = READ;
`endif
        end
      end
      READ: begin
        load = !out_valid || out_ready;
        step = load;
        if (load && (remaining == REM_ONE)) state_next = IDLE;
      end
`ifdef MEM_FILL_EN
      FILL: begin
        mem_w_write = 1'b1;
        mem_w_data  = fill_data;
        step        = 1'b1;
        if (remaining == REM_ONE) state_next = IDLE;
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      addr      <= '0;
      remaining <= '0;
    end else if (start_cmd) begin
      addr      <= cmd_start;
      remaining <= cmd_count;
    end else if (step) begin
      addr      <= addr_next;
      remaining <= remaining - 1'b1;
    end
  end

`ifdef MEM_FILL_EN
  always_ff @(posedge clk) begin
    if (!reset_n)                  fill_data <= '0;
    else if (start_cmd && cmd_fill) fill_data <= cmd_fill_data;
  end
`endif

  // Output register: reload on load, otherwise drop the word once it is taken.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= mem_r_data;
      out_last  <= (remaining == REM_ONE);
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_stream_reader.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for mem_stream_reader: queue-based reference model plus directed literal checks.
module tb_mem_stream_reader;
  localparam int WIDTH = 16;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             cmd_valid = 1'b0;
  logic             cmd_ready;
  logic [AW-1:0]    cmd_start = '0;
  logic [AW:0]      cmd_count = '0;
`ifdef MEM_FILL_EN
  logic             cmd_fill = 1'b0;
  logic [WIDTH-1:0] cmd_fill_data = '0;
`endif
  logic [AW-1:0]    mem_address;
  logic [WIDTH-1:0] mem_w_data;
  logic             mem_w_write;
  logic [WIDTH-1:0] mem_r_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic             busy;

  logic rand_mode = 1'b0;
  logic fixed_ready = 1'b1;
  logic rnd_bit = 1'b1;
  assign out_ready = rand_mode ? rnd_bit : fixed_ready;

  // Memory attached to the DUT: async read, sync write, preloaded with k + 0x100.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             loaded = 1'b0;
  assign mem_r_data = mem[mem_address];
  always @(posedge clk) begin
    if (!loaded) begin
      for (int k = 0; k < DEPTH; k++) mem[k] <= 16'h0100 + 16'(k);
      loaded <= 1'b1;
    end else if (mem_w_write) begin
      mem[mem_address] <= mem_w_data;
    end
  end

  always #5 clk = ~clk;
  always @(posedge clk) begin #1; rnd_bit = 1'($urandom); end

  mem_stream_reader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_start(cmd_start), .cmd_count(cmd_count),
`ifdef MEM_FILL_EN
    .cmd_fill(cmd_fill), .cmd_fill_data(cmd_fill_data),
`endif
    .mem_address(mem_address), .mem_w_data(mem_w_data), .mem_w_write(mem_w_write),
    .mem_r_data(mem_r_data),
    .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_ready(out_ready), .busy(busy)
  );

  int compared = 0;
  int mismatched = 0;

  logic [WIDTH-1:0] ref_mem [DEPTH];
  logic [16:0] exp_words[$];   // {last, data}
  logic [19:0] exp_writes[$];  // {addr, data}
  logic [16:0] got[$];
  int          wlog[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare process: one transfer or write per cycle, checked against the model queues.
  logic             stall_prev = 1'b0;
  logic [WIDTH-1:0] held_data;
  logic             held_last;
  logic [AW-1:0]    held_addr;
  always @(negedge clk) begin
    if (!reset_n) begin
      exp_words.delete();
      exp_writes.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev && out_valid) begin
        check("stall_data", 32'(out_data), 32'(held_data));
        check("stall_last", 32'(out_last), 32'(held_last));
        if (!held_last) check("stall_addr", 32'(mem_address), 32'(held_addr));
      end
      if (out_valid && out_ready) begin
        got.push_back({out_last, out_data});
        if (exp_words.size() == 0) begin
          check("unexpected_word", 32'({out_last, out_data}), 32'h1ffff);
        end else begin
          logic [16:0] e;
          e = exp_words.pop_front();
          check("word_data", 32'(out_data), 32'(e[15:0]));
          check("word_last", 32'(out_last), 32'(e[16]));
        end
      end
      stall_prev = out_valid && !out_ready;
      held_data  = out_data;
      held_last  = out_last;
      held_addr  = mem_address;
      if (mem_w_write) begin
        wlog.push_back(int'(mem_address));
        if (exp_writes.size() == 0) begin
          check("unexpected_write", 32'(mem_address), 32'hffff);
        end else begin
          logic [19:0] w;
          w = exp_writes.pop_front();
          check("write_addr", 32'(mem_address), 32'(w[19:16]));
          check("write_data", 32'(mem_w_data), 32'(w[15:0]));
        end
      end
    end
  end

  task automatic send_cmd(input int start, input int count, input bit fill, input logic [15:0] val);
    int guard;
    bit do_fill;
    guard = 0;
`ifdef MEM_FILL_EN
    do_fill = fill;
`else
    do_fill = 1'b0 & fill;
`endif
    @(negedge clk);
    while (!cmd_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 300) check("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_start = AW'(start);
    cmd_count = (AW+1)'(count);
`ifdef MEM_FILL_EN
    cmd_fill      = do_fill;
    cmd_fill_data = val;
`endif
    for (int i = 0; i < count; i++) begin
      int a;
      a = (start + i) % DEPTH;
      if (do_fill) begin
        exp_writes.push_back({4'(a), val});
        ref_mem[a] = val;
      end else begin
        exp_words.push_back({(i == count - 1), ref_mem[a]});
      end
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int guard;
    guard = 0;
    while (got.size() < n && guard < 200) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (guard >= 200) check("wait_words_timeout", 32'(got.size()), 32'(n));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"},  32'(out_data), 32'd0);
    check({tag, "_last"},  32'(out_last), 32'd0);
    check({tag, "_addr"},  32'(mem_address), 32'd0);
    check({tag, "_wr"},    32'(mem_w_write), 32'd0);
    check({tag, "_busy"},  32'(busy), 32'd0);
    check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
  endtask

  initial begin
    logic [16:0] e;
    int pat [5];
    int guard;
    pat = '{1, 0, 0, 1, 1};
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 16'h0100 + 16'(k);
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    reset_n = 1'b1;

    // Basic read with latency and throughput.
    got.delete();
    send_cmd(3, 4, 1'b0, 16'h0);
    @(negedge clk);
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    check("lat_read_addr", 32'(mem_address), 32'd3);
    @(negedge clk);
    check("lat_first_valid", 32'(out_valid), 32'd1);
    check("lat_first_data", 32'(out_data), 32'h0103);
    repeat (4) @(posedge clk);
    #1;
    check("throughput_words", 32'(got.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      e = {(i == 3), 16'h0103 + 16'(i)};
      check("basic_word", 32'(got[i]), 32'(e));
    end

    // Address wrap.
    got.delete();
    send_cmd(14, 4, 1'b0, 16'h0);
    wait_got(4);
    check("wrap_w0", 32'(got[0]), 32'h0010e);
    check("wrap_w1", 32'(got[1]), 32'h0010f);
    check("wrap_w2", 32'(got[2]), 32'h00100);
    check("wrap_w3", 32'(got[3]), 32'h10101);

    // Backpressure with ready pattern 1,0,0,1,1.
    got.delete();
    send_cmd(0, 3, 1'b0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      fixed_ready = pat[i][0];
      if (i == 1 || i == 2) begin
        @(negedge clk);
        check("bp_hold_data", 32'(out_data), 32'h0100);
        check("bp_hold_addr", 32'(mem_address), 32'd1);
      end
      @(posedge clk);
      #1;
    end
    fixed_ready = 1'b1;
    wait_got(3);
    check("bp_count", 32'(got.size()), 32'd3);
    check("bp_w0", 32'(got[0]), 32'h00100);
    check("bp_w1", 32'(got[1]), 32'h00101);
    check("bp_w2", 32'(got[2]), 32'h10102);

    // Zero-count command is a no-op.
    got.delete();
    send_cmd(9, 0, 1'b0, 16'h0);
    repeat (3) begin
      @(negedge clk);
      check("zero_valid", 32'(out_valid), 32'd0);
      check("zero_ready", 32'(cmd_ready), 32'd1);
    end
    send_cmd(5, 1, 1'b0, 16'h0);
    wait_got(1);
    check("single_word", 32'(got[0]), 32'h10105);

`ifdef MEM_FILL_EN
    // Fill then read back across it.
    got.delete();
    wlog.delete();
    send_cmd(6, 3, 1'b1, 16'hBEEF);
    send_cmd(5, 5, 1'b0, 16'h0);
    wait_got(5);
    check("fill_writes", 32'(wlog.size()), 32'd3);
    check("fill_a0", 32'(wlog[0]), 32'd6);
    check("fill_a1", 32'(wlog[1]), 32'd7);
    check("fill_a2", 32'(wlog[2]), 32'd8);
    check("fill_r0", 32'(got[0]), 32'h00105);
    check("fill_r1", 32'(got[1]), 32'h0beef);
    check("fill_r2", 32'(got[2]), 32'h0beef);
    check("fill_r3", 32'(got[3]), 32'h0beef);
    check("fill_r4", 32'(got[4]), 32'h10109);
`endif

    // Reset in the middle of a read.
    got.delete();
    send_cmd(0, 8, 1'b0, 16'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check_reset_state("midreset");
    reset_n = 1'b1;
    got.delete();
    send_cmd(2, 3, 1'b0, 16'h0);
    wait_got(3);
    check("post_reset_w0", 32'(got[0]), 32'(17'h00000 | 17'(ref_mem[2])));
    check("post_reset_w2", 32'(got[2]), 32'(17'h10000 | 17'(ref_mem[4])));

    // Randomized commands with random backpressure.
    rand_mode = 1'b1;
    repeat (30) begin
      send_cmd(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, 20)),
               ($urandom_range(0, 2) == 0), 16'($urandom));
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
    end
    guard = 0;
    while ((exp_words.size() != 0 || exp_writes.size() != 0 || busy) && guard < 2000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    rand_mode = 1'b0;
    check("drain_words", 32'(exp_words.size()), 32'd0);
    check("drain_writes", 32'(exp_writes.size()), 32'd0);
    check("drain_busy", 32'(busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
`default_nettype wire
